// File: rtl/uart_rx_sampler_pkg.sv
// Shared UART receive definitions: FSM state encoding and the mid-bit sample point.
// The TX side imports the same package so both directions agree on these values.
package uart_rx_sampler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   function automatic int mid_tick(input int oversample);
      return oversample / 2;
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input.
// RESET_VAL sets the value both flops hold in reset, e.g. 1 for an idle-high serial line.
module uart_bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: glitch-rejecting start detection, 3-sample majority per bit,
// parity/framing checks and a valid/ready output slice with sticky overrun.
//
//   state     | meaning
//   ST_IDLE   | line idle; waits for a low sample (only once re-armed by a high sample)
//   ST_START  | validating the start bit; a high majority is a false start
//   ST_DATA   | shifting in DATA_BITS bits, LSB first
//   ST_PARITY | checking the parity bit (PARITY_EN only)
//   ST_STOP   | deciding the stop bit; completes at the mid-bit decision point
module uart_rx_sampler
   import uart_rx_sampler_pkg::*;
#(
   parameter int RX_OVERSAMPLE = 16,
   parameter int DATA_BITS     = 8,
   parameter int PARITY_EN     = 0,
   parameter int PARITY_ODD    = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_Rx_ClkTick,
   input  logic                 i_Rx_Data,
   input  logic                 i_Rx_Ready,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Rx_Valid,
   output logic                 o_Frame_Err,
   output logic                 o_Parity_Err,
   output logic                 o_Overrun,
   output logic                 o_Rx_Busy
);

   localparam int TW  = $clog2(RX_OVERSAMPLE);
   localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int MID = mid_tick(RX_OVERSAMPLE);

   localparam logic [TW-1:0] T_PRE  = TW'(MID - 1);
   localparam logic [TW-1:0] T_MID  = TW'(MID);
   localparam logic [TW-1:0] T_DEC  = TW'(MID + 1);
   localparam logic [TW-1:0] T_LAST = TW'(RX_OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   localparam logic          ODD    = (PARITY_ODD != 0);

   logic                 rx_s;
   rx_state_t            state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic                 samp_a;
   logic                 samp_b;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err_p;
   logic                 frm_err_p;
   logic                 done;
   logic                 armed;
   logic                 vote;
   logic                 parity_exp;

   uart_bit_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (i_Rx_Data),
      .q       (rx_s)
   );

   // Third sample is the live one at the decision tick
   assign vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
   assign parity_exp = (^shreg) ^ ODD;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         samp_a    <= 1'b0;
         samp_b    <= 1'b0;
         shreg     <= '0;
         par_err_p <= 1'b0;
         frm_err_p <= 1'b0;
         done      <= 1'b0;
         armed     <= 1'b1;
         o_Rx_Busy <= 1'b0;
      end else begin
         done <= 1'b0;
         if (i_Rx_ClkTick) begin
            if (tick_cnt == T_PRE) samp_a <= rx_s;
            if (tick_cnt == T_MID) samp_b <= rx_s;
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            case (state)
               ST_IDLE: begin
                  tick_cnt <= '0;
                  if (rx_s) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state     <= ST_START;
                     o_Rx_Busy <= 1'b1;
                     par_err_p <= 1'b0;
                  end
               end
               ST_START: begin
                  if (tick_cnt == T_DEC && vote) begin
                     state     <= ST_IDLE;
                     o_Rx_Busy <= 1'b0;
                     tick_cnt  <= '0;
                  end else if (tick_cnt == T_LAST) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  if (tick_cnt == T_DEC) shreg <= {vote, shreg[DATA_BITS-1:1]};
                  if (tick_cnt == T_LAST) begin
                     if (bit_cnt == B_LAST) begin
                        bit_cnt <= '0;
                        state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               ST_PARITY: begin
                  if (tick_cnt == T_DEC && vote != parity_exp) par_err_p <= 1'b1;
                  if (tick_cnt == T_LAST) state <= ST_STOP;
               end
               ST_STOP: begin
                  if (tick_cnt == T_DEC) begin
                     frm_err_p <= ~vote;
                     done      <= 1'b1;
                     state     <= ST_IDLE;
                     o_Rx_Busy <= 1'b0;
                     tick_cnt  <= '0;
                     // A held-low line must go high before the next start counts
                     armed     <= 1'b0;
                  end
               end
               default: begin
                  state     <= ST_IDLE;
                  o_Rx_Busy <= 1'b0;
                  tick_cnt  <= '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_Rx_Byte    <= '0;
         o_Rx_Valid   <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Parity_Err <= 1'b0;
         o_Overrun    <= 1'b0;
      end else if (done) begin
         if (!o_Rx_Valid || i_Rx_Ready) begin
            o_Rx_Byte    <= shreg;
            o_Frame_Err  <= frm_err_p;
            o_Parity_Err <= par_err_p;
            o_Rx_Valid   <= 1'b1;
            o_Overrun    <= 1'b0;
         end else begin
            o_Overrun <= 1'b1;
         end
      end else if (o_Rx_Valid && i_Rx_Ready) begin
         o_Rx_Valid   <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Parity_Err <= 1'b0;
         o_Overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: a default instance plus an even-parity instance,
// each fed from its own serial line with frames built tick by tick.
module tb_uart_rx_sampler;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       rx_line = 1'b1;
   logic       sel = 1'b0;
   logic       ready0 = 1'b1;
   logic       ready1 = 1'b1;
   logic       rx0, rx1;

   logic [7:0] byte0, byte1;
   logic       valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

   int vectors = 0;
   int miscompares = 0;

   int         n_v0 = 0, n_v1 = 0;
   logic [7:0] cb0 = '0, cb1 = '0;
   logic       cfe0 = 1'b0, cpe0 = 1'b0, cfe1 = 1'b0, cpe1 = 1'b0;
   logic       busy_seen0 = 1'b0;

   assign rx0 = sel ? 1'b1 : rx_line;
   assign rx1 = sel ? rx_line : 1'b1;

   uart_rx_sampler dut0 (
      .clk(clk), .reset_n(reset_n), .i_Rx_ClkTick(tick), .i_Rx_Data(rx0),
      .i_Rx_Ready(ready0), .o_Rx_Byte(byte0), .o_Rx_Valid(valid0),
      .o_Frame_Err(fe0), .o_Parity_Err(pe0), .o_Overrun(ov0), .o_Rx_Busy(busy0)
   );

   uart_rx_sampler #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clk(clk), .reset_n(reset_n), .i_Rx_ClkTick(tick), .i_Rx_Data(rx1),
      .i_Rx_Ready(ready1), .o_Rx_Byte(byte1), .o_Rx_Valid(valid1),
      .o_Frame_Err(fe1), .o_Parity_Err(pe1), .o_Overrun(ov1), .o_Rx_Busy(busy1)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (3) @(posedge clk);
         #1 tick = 1'b1;
         @(posedge clk);
         #1 tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (valid0) begin
         n_v0++;
         cb0  = byte0;
         cfe0 = fe0;
         cpe0 = pe0;
      end
      if (valid1) begin
         n_v1++;
         cb1  = byte1;
         cfe1 = fe1;
         cpe1 = pe1;
      end
      if (busy0) busy_seen0 = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_tick();
      do @(posedge clk); while (!tick);
   endtask

   task automatic idle(input int n);
      rx_line = 1'b1;
      repeat (n) wait_tick();
      #1;
   endtask

   task automatic drive_bit(input logic v, input int inv_pos);
      for (int j = 0; j < 16; j++) begin
         rx_line = (j == inv_pos) ? ~v : v;
         wait_tick();
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit par_en,
                             input logic par_v, input bit noisy);
      drive_bit(1'b0, -1);
      for (int i = 0; i < 8; i++) drive_bit(d[i], noisy ? 7 + (i % 3) : -1);
      if (par_en) drive_bit(par_v, -1);
      drive_bit(stop_v, -1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({byte0, valid0, fe0, pe0, ov0, busy0} !== 13'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h required 0", {byte0, valid0, fe0, pe0, ov0, busy0});
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(8);
   endtask

   task automatic test_basic_frame();
      int n0, c0;
      n0 = n_v0;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      c0 = n_v0 - n0;
      vectors++;
      if (c0 != 1) begin
         miscompares++;
         $display("FAIL a5_valid_cycles: got %0d required 1", c0);
      end
      vectors++;
      if (cb0 !== 8'hA5) begin
         miscompares++;
         $display("FAIL a5_byte: got %h required a5", cb0);
      end
      vectors++;
      if ({cfe0, cpe0} !== 2'b00) begin
         miscompares++;
         $display("FAIL a5_errors: got %b required 00", {cfe0, cpe0});
      end
   endtask

   task automatic test_glitch();
      int n0;
      bit cleared;
      n0 = n_v0;
      busy_seen0 = 1'b0;
      rx_line = 1'b0;
      repeat (2) wait_tick();
      #1 rx_line = 1'b1;
      cleared = 1'b0;
      for (int k = 0; k < 16 && !cleared; k++) begin
         wait_tick();
         @(negedge clk);
         if (!busy0) cleared = 1'b1;
      end
      #1;
      vectors++;
      if (busy_seen0 !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_busy_seen: got %b required 1", busy_seen0);
      end
      vectors++;
      if (!cleared) begin
         miscompares++;
         $display("FAIL glitch_busy_clear: busy got 1 after 16 ticks required 0");
      end
      idle(40);
      vectors++;
      if (n_v0 != n0) begin
         miscompares++;
         $display("FAIL glitch_no_valid: got %0d words required 0", n_v0 - n0);
      end
   endtask

   task automatic test_majority();
      int n0;
      n0 = n_v0;
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);
      vectors++;
      if (n_v0 - n0 != 1 || cb0 !== 8'h3C || cfe0 !== 1'b0) begin
         miscompares++;
         $display("FAIL noisy_3c: got words=%0d byte=%h fe=%b required 1/3c/0", n_v0 - n0, cb0, cfe0);
      end
   endtask

   task automatic test_frame_err();
      int n0;
      n0 = n_v0;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(8);
      vectors++;
      if (cb0 !== 8'h55) begin
         miscompares++;
         $display("FAIL ferr_byte: got %h required 55", cb0);
      end
      vectors++;
      if (n_v0 - n0 != 1 || cfe0 !== 1'b1) begin
         miscompares++;
         $display("FAIL ferr_flag: got words=%0d fe=%b required 1/1", n_v0 - n0, cfe0);
      end
   endtask

   task automatic test_break();
      int n0;
      n0 = n_v0;
      rx_line = 1'b0;
      repeat (320) wait_tick();
      #1;
      idle(20);
      vectors++;
      if (n_v0 - n0 != 1 || cb0 !== 8'h00 || cfe0 !== 1'b1) begin
         miscompares++;
         $display("FAIL break: got words=%0d byte=%h fe=%b required 1/00/1", n_v0 - n0, cb0, cfe0);
      end
   endtask

   task automatic test_parity();
      int n1;
      sel = 1'b1;
      idle(4);
      n1 = n_v1;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(4);
      vectors++;
      if (n_v1 - n1 != 1 || cb1 !== 8'h07 || cpe1 !== 1'b1 || cfe1 !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_bad: got words=%0d byte=%h pe=%b fe=%b required 1/07/1/0",
                  n_v1 - n1, cb1, cpe1, cfe1);
      end
      n1 = n_v1;
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(4);
      vectors++;
      if (n_v1 - n1 != 1 || cb1 !== 8'h07 || cpe1 !== 1'b0 || cfe1 !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_good: got words=%0d byte=%h pe=%b fe=%b required 1/07/0/0",
                  n_v1 - n1, cb1, cpe1, cfe1);
      end
      sel = 1'b0;
      idle(4);
   endtask

   task automatic test_back_to_back();
      ready0 = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      @(negedge clk);
      vectors++;
      if ({valid0, byte0, ov0} !== {1'b1, 8'h11, 1'b1}) begin
         miscompares++;
         $display("FAIL overrun_hold: got valid=%b byte=%h ov=%b required 1/11/1", valid0, byte0, ov0);
      end
      @(posedge clk);
      #1 ready0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({valid0, ov0, fe0, pe0} !== 4'b0000) begin
         miscompares++;
         $display("FAIL overrun_clear: got %b required 0000", {valid0, ov0, fe0, pe0});
      end
      #1;
      idle(4);
   endtask

   task automatic test_reset_mid_frame();
      int n0;
      logic [7:0] d;
      d = 8'hF0;
      n0 = n_v0;
      drive_bit(1'b0, -1);
      for (int i = 0; i < 4; i++) drive_bit(d[i], -1);
      rx_line = d[4];
      repeat (8) wait_tick();
      #1 reset_n = 1'b0;
      rx_line = 1'b1;
      @(negedge clk);
      vectors++;
      if ({byte0, valid0, fe0, pe0, ov0, busy0} !== 13'h0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got %h required 0", {byte0, valid0, fe0, pe0, ov0, busy0});
      end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(20);
      vectors++;
      if (n_v0 != n0) begin
         miscompares++;
         $display("FAIL midreset_no_word: got %0d words required 0", n_v0 - n0);
      end
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      vectors++;
      if (n_v0 - n0 != 1 || cb0 !== 8'h81 || cfe0 !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_next_81: got words=%0d byte=%h fe=%b required 1/81/0", n_v0 - n0, cb0, cfe0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_glitch();
      test_majority();
      test_frame_err();
      test_break();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
